// File: rtl/idelay_sweep_pkg.sv
// Shared types and constants for the delay-line tap sweep controller.
package idelay_sweep_pkg;

   localparam int DEF_TAP_W = 5;
   localparam int MAX_TAP   = (1 << DEF_TAP_W) - 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      LOAD,
      SETTLE,
      SAMPLE,
      REPORT,
      DONE
   } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level signal.
// Latency: 2 clk cycles. Backpressure: none, level signal only.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/idelay_sweep_ctrl.sv
// Steps the delay tap over [first_tap, last_tap], settles, counts sense_in ones per tap.
// Latency per tap: 1 load + SETTLE_CYC + SAMPLE_CNT cycles, plus result handshake.
// Backpressure: result is held in REPORT, with delay frozen, until res_ready.
module idelay_sweep_ctrl
   import idelay_sweep_pkg::*;
#(
   parameter int TAP_W      = DEF_TAP_W,
   parameter int SETTLE_CYC = 8,
   parameter int SAMPLE_CNT = 256,
   parameter int CNT_W      = 9
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [TAP_W-1:0] first_tap,
   input  logic [TAP_W-1:0] last_tap,
   input  logic             idelay_rdy,
   input  logic             sense_in,
   output logic [TAP_W-1:0] delay,
   output logic             ld,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TAP_W-1:0] res_tap,
   output logic [CNT_W-1:0] res_ones,
   output logic             done,
   output logic             err
);

   localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(SAMPLE_CNT - 1);

   state_t           state;
   logic             rdy_s;
   logic [TAP_W-1:0] tap;
   logic [TAP_W-1:0] last_r;
   logic [SET_W-1:0] settle_cnt;
   logic [CNT_W-1:0] ones_cnt;
   logic [CNT_W-1:0] smp_cnt;
   logic [CNT_W-1:0] ones_nxt;

   sync_2ff u_rdy_sync (
      .clk   (clk_in),
      .rst_n (rst_n),
      .d     (idelay_rdy),
      .q     (rdy_s)
   );

   assign ones_nxt = ones_cnt + CNT_W'(sense_in);
   assign busy     = (state != IDLE);

   // delay and ld are registered on the transition into LOAD so both are visible in LOAD itself.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tap        <= '0;
         last_r     <= '0;
         settle_cnt <= '0;
         ones_cnt   <= '0;
         smp_cnt    <= '0;
         delay      <= '0;
         ld         <= 1'b0;
         res_valid  <= 1'b0;
         res_tap    <= '0;
         res_ones   <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         ld   <= 1'b0;
         done <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            res_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     if (last_tap >= first_tap) begin
                        tap    <= first_tap;
                        last_r <= last_tap;
                        err    <= 1'b0;
                        state  <= WAIT_RDY;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               WAIT_RDY: begin
                  if (rdy_s) begin
                     delay <= tap;
                     ld    <= 1'b1;
                     state <= LOAD;
                  end
               end
               LOAD: begin
                  settle_cnt <= SET_LOAD;
                  state      <= SETTLE;
               end
               SETTLE: begin
                  if (!rdy_s) begin
                     err   <= 1'b1;
                     state <= WAIT_RDY;
                  end else if (settle_cnt == '0) begin
                     ones_cnt <= '0;
                     smp_cnt  <= '0;
                     state    <= SAMPLE;
                  end else begin
                     settle_cnt <= settle_cnt - 1'b1;
                  end
               end
               SAMPLE: begin
                  if (!rdy_s) begin
                     // partial counts are dropped; the same tap is reloaded once RDY returns
                     err      <= 1'b1;
                     ones_cnt <= '0;
                     smp_cnt  <= '0;
                     state    <= WAIT_RDY;
                  end else if (smp_cnt == LAST_SMP) begin
                     res_tap   <= tap;
                     res_ones  <= ones_nxt;
                     res_valid <= 1'b1;
                     state     <= REPORT;
                  end else begin
                     ones_cnt <= ones_nxt;
                     smp_cnt  <= smp_cnt + 1'b1;
                  end
               end
               REPORT: begin
                  if (res_ready) begin
                     res_valid <= 1'b0;
                     if (tap == last_r) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        tap   <= tap + 1'b1;
                        delay <= tap + 1'b1;
                        ld    <= 1'b1;
                        state <= LOAD;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
// Bench for idelay_sweep_ctrl: scenario tasks checked against a cycle-history model of the sweep.
module tb_idelay_sweep_ctrl;

   localparam int SETTLE  = 8;
   localparam int SAMPLES = 256;
   localparam int HIST_N  = 65536;

   logic       clk_in = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [4:0] first_tap = '0;
   logic [4:0] last_tap = '0;
   logic       idelay_rdy = 1'b0;
   logic       sense_in = 1'b0;
   logic       res_ready = 1'b0;
   logic [4:0] delay;
   logic       ld;
   logic       busy;
   logic       res_valid;
   logic [4:0] res_tap;
   logic [8:0] res_ones;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   bit hist [0:HIST_N-1];
   int ld_cyc_q[$];
   int ld_dly_q[$];
   int res_tap_q[$];
   int res_ones_q[$];
   int done_n = 0;
   int sense_mode = 3;   // 0: all ones, 1: toggle, 2: random, 3: all zeros
   int ready_mode = 0;   // 0: low, 1: high, 2: random

   idelay_sweep_ctrl dut (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .first_tap  (first_tap),
      .last_tap   (last_tap),
      .idelay_rdy (idelay_rdy),
      .sense_in   (sense_in),
      .delay      (delay),
      .ld         (ld),
      .busy       (busy),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_tap    (res_tap),
      .res_ones   (res_ones),
      .done       (done),
      .err        (err)
   );

   initial forever #5 clk_in = ~clk_in;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   initial begin
      forever begin
         @(posedge clk_in);
         #2;
         case (sense_mode)
            0:       sense_in = 1'b1;
            1:       sense_in = ~sense_in;
            2:       sense_in = 1'($urandom_range(0, 1));
            default: sense_in = 1'b0;
         endcase
         case (ready_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Records what the DUT does each cycle; an abort cycle never counts as an accepted result.
   initial begin
      forever begin
         @(negedge clk_in);
         cyc_n++;
         if (cyc_n < HIST_N) hist[cyc_n] = sense_in;
         if (ld) begin
            ld_cyc_q.push_back(cyc_n);
            ld_dly_q.push_back(int'(delay));
         end
         if (res_valid && res_ready && !abort && rst_n) begin
            res_tap_q.push_back(int'(res_tap));
            res_ones_q.push_back(int'(res_ones));
         end
         if (done) done_n++;
      end
   end

   // The sampled window starts SETTLE+1 cycles after the ld cycle and spans SAMPLES cycles.
   function automatic int exp_ones(input int ldc);
      int s;
      s = 0;
      for (int i = ldc + SETTLE + 1; i <= ldc + SETTLE + SAMPLES; i++)
         if (i >= 0 && i < HIST_N) s += int'(hist[i]);
      return s;
   endfunction

   task automatic clear_mon();
      ld_cyc_q.delete();
      ld_dly_q.delete();
      res_tap_q.delete();
      res_ones_q.delete();
      done_n = 0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_start(input int f, input int l);
      tick();
      first_tap = 5'(f);
      last_tap  = 5'(l);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ld(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (ld) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #23;
      checks++;
      if ({delay, ld, busy, res_valid, res_tap, res_ones, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_hold: outputs %h, required 0",
                  {delay, ld, busy, res_valid, res_tap, res_ones, done, err});
      end
      @(negedge clk_in);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
      checks++;
      if ({delay, ld, busy, res_valid, res_tap, res_ones, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_release: outputs %h, required 0",
                  {delay, ld, busy, res_valid, res_tap, res_ones, done, err});
      end
      idelay_rdy = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_basic_sweep();
      bit ok;
      clear_mon();
      sense_mode = 0;
      ready_mode = 1;
      do_start(3, 5);
      wait_idle(1200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: busy still 1, required 0"); end
      checks++;
      if (res_tap_q.size() !== 3 || ld_cyc_q.size() !== 3) begin
         errors++;
         $display("FAIL basic_count: results %0d ld %0d, required 3 and 3", res_tap_q.size(), ld_cyc_q.size());
      end
      for (int i = 0; i < 3 && i < res_tap_q.size() && i < ld_cyc_q.size(); i++) begin
         checks++;
         if (res_tap_q[i] !== 3 + i || res_ones_q[i] !== 256 || ld_dly_q[i] !== 3 + i
             || res_ones_q[i] !== exp_ones(ld_cyc_q[i])) begin
            errors++;
            $display("FAIL basic_result%0d: tap %0d ones %0d delay %0d, required tap %0d ones 256 delay %0d",
                     i, res_tap_q[i], res_ones_q[i], ld_dly_q[i], 3 + i, 3 + i);
         end
      end
      checks++;
      if (done_n !== 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done pulses %0d err %0b, required 1 and 0", done_n, err);
      end
   endtask

   task automatic test_half_ones();
      bit ok;
      clear_mon();
      sense_mode = 1;
      ready_mode = 1;
      do_start(31, 31);
      wait_idle(600, ok);
      checks++;
      if (!ok || res_tap_q.size() !== 1 || done_n !== 1 || ld_cyc_q.size() !== 1) begin
         errors++;
         $display("FAIL half_count: ok %0b results %0d done %0d ld %0d, required 1 1 1 1",
                  ok, res_tap_q.size(), done_n, ld_cyc_q.size());
      end else begin
         checks++;
         if (res_tap_q[0] !== 31 || res_ones_q[0] !== 128 || res_ones_q[0] !== exp_ones(ld_cyc_q[0])) begin
            errors++;
            $display("FAIL half_result: tap %0d ones %0d, required 31 and 128", res_tap_q[0], res_ones_q[0]);
         end
      end
      repeat (5) @(negedge clk_in);
      checks++;
      if (delay !== 5'd31 || busy !== 1'b0) begin
         errors++;
         $display("FAIL half_nowrap: delay %0d busy %0b, required 31 and 0", delay, busy);
      end
   endtask

   task automatic test_random_sweep();
      bit ok;
      int f, l, n;
      for (int it = 0; it < 3; it++) begin
         clear_mon();
         f = $urandom_range(0, 29);
         l = f + $urandom_range(0, 2);
         n = l - f + 1;
         sense_mode = 2;
         ready_mode = 2;
         do_start(f, l);
         wait_idle(400 * n + 50, ok);
         checks++;
         if (!ok || res_tap_q.size() !== n || ld_cyc_q.size() !== n || done_n !== 1) begin
            errors++;
            $display("FAIL rand%0d_count: ok %0b results %0d ld %0d done %0d, required %0d %0d 1",
                     it, ok, res_tap_q.size(), ld_cyc_q.size(), done_n, n, n);
         end else begin
            for (int i = 0; i < n; i++) begin
               checks++;
               if (res_tap_q[i] !== f + i || ld_dly_q[i] !== f + i || res_ones_q[i] !== exp_ones(ld_cyc_q[i])) begin
                  errors++;
                  $display("FAIL rand%0d_result%0d: tap %0d delay %0d ones %0d, required tap %0d ones %0d",
                           it, i, res_tap_q[i], ld_dly_q[i], res_ones_q[i], f + i, exp_ones(ld_cyc_q[i]));
               end
            end
         end
      end
      ready_mode = 1;
   endtask

   task automatic test_backpressure();
      bit ok, bad;
      int eo;
      clear_mon();
      sense_mode = 2;
      ready_mode = 0;
      do_start(7, 8);
      wait_valid(400, ok);
      checks++;
      if (!ok || ld_cyc_q.size() !== 1) begin
         errors++;
         $display("FAIL bp_valid: ok %0b ld %0d, required 1 and 1", ok, ld_cyc_q.size());
      end else begin
         eo  = exp_ones(ld_cyc_q[0]);
         bad = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            checks++;
            if (res_valid !== 1'b1 || res_tap !== 5'd7 || int'(res_ones) !== eo || delay !== 5'd7) begin
               errors++;
               $display("FAIL bp_hold%0d: valid %0b tap %0d ones %0d delay %0d, required 1 7 %0d 7",
                        c, res_valid, res_tap, res_ones, delay, eo);
            end
         end
      end
      tick();
      ready_mode = 1;
      wait_idle(600, ok);
      checks++;
      if (!ok || res_tap_q.size() !== 2 || ld_dly_q.size() !== 2 || done_n !== 1) begin
         errors++;
         $display("FAIL bp_finish: ok %0b results %0d ld %0d done %0d, required 1 2 2 1",
                  ok, res_tap_q.size(), ld_dly_q.size(), done_n);
      end else begin
         checks++;
         if (res_tap_q[0] !== 7 || res_tap_q[1] !== 8 || ld_dly_q[1] !== 8
             || res_ones_q[1] !== exp_ones(ld_cyc_q[1])) begin
            errors++;
            $display("FAIL bp_results: taps %0d,%0d ones %0d, required 7,8 ones %0d",
                     res_tap_q[0], res_tap_q[1], res_ones_q[1], exp_ones(ld_cyc_q[1]));
         end
      end
   endtask

   task automatic test_rdy_gating();
      bit ok;
      int n;
      clear_mon();
      sense_mode = 0;
      ready_mode = 1;
      idelay_rdy = 1'b0;
      repeat (4) tick();
      do_start(2, 2);
      repeat (10) @(negedge clk_in);
      checks++;
      if (ld_cyc_q.size() !== 0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL gate_noload: ld %0d busy %0b, required 0 and 1", ld_cyc_q.size(), busy);
      end
      tick();
      idelay_rdy = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_in);
         n++;
         @(negedge clk_in);
         if (ld) break;
      end
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL gate_latency: ld after %0d cycles, required 3", n);
      end
      repeat (40) tick();
      idelay_rdy = 1'b0;
      repeat (6) tick();
      @(negedge clk_in);
      checks++;
      if (err !== 1'b1 || busy !== 1'b1 || res_tap_q.size() !== 0 || ld_cyc_q.size() !== 1) begin
         errors++;
         $display("FAIL gate_loss: err %0b busy %0b results %0d ld %0d, required 1 1 0 1",
                  err, busy, res_tap_q.size(), ld_cyc_q.size());
      end
      idelay_rdy = 1'b1;
      wait_idle(700, ok);
      checks++;
      if (!ok || ld_cyc_q.size() !== 2 || res_tap_q.size() !== 1 || done_n !== 1) begin
         errors++;
         $display("FAIL gate_retry_count: ok %0b ld %0d results %0d done %0d, required 1 2 1 1",
                  ok, ld_cyc_q.size(), res_tap_q.size(), done_n);
      end else begin
         checks++;
         if (ld_dly_q[0] !== 2 || ld_dly_q[1] !== 2 || res_tap_q[0] !== 2 || res_ones_q[0] !== 256
             || res_ones_q[0] !== exp_ones(ld_cyc_q[1]) || err !== 1'b1) begin
            errors++;
            $display("FAIL gate_retry: delays %0d,%0d tap %0d ones %0d err %0b, required 2,2 2 256 1",
                     ld_dly_q[0], ld_dly_q[1], res_tap_q[0], res_ones_q[0], err);
         end
      end
   endtask

   task automatic test_abort();
      bit ok;
      clear_mon();
      sense_mode = 0;
      ready_mode = 1;
      do_start(4, 6);
      wait_ld(50, ok);
      repeat (20) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      @(negedge clk_in);
      checks++;
      if (!ok || busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_sample: ld seen %0b busy %0b valid %0b, required 1 0 0", ok, busy, res_valid);
      end
      repeat (300) @(negedge clk_in);
      checks++;
      if (res_tap_q.size() !== 0 || done_n !== 0 || ld_cyc_q.size() !== 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL abort_sample_after: results %0d done %0d ld %0d err %0b, required 0 0 1 0",
                  res_tap_q.size(), done_n, ld_cyc_q.size(), err);
      end
      clear_mon();
      ready_mode = 0;
      do_start(4, 6);
      wait_valid(400, ok);
      tick();
      abort = 1'b1;
      ready_mode = 1;
      tick();
      abort = 1'b0;
      @(negedge clk_in);
      checks++;
      if (!ok || busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_report: valid seen %0b busy %0b valid %0b, required 1 0 0", ok, busy, res_valid);
      end
      repeat (30) @(negedge clk_in);
      checks++;
      if (res_tap_q.size() !== 0 || done_n !== 0 || ld_cyc_q.size() !== 1 || delay !== 5'd4) begin
         errors++;
         $display("FAIL abort_report_after: results %0d done %0d ld %0d delay %0d, required 0 0 1 4",
                  res_tap_q.size(), done_n, ld_cyc_q.size(), delay);
      end
   endtask

   task automatic test_bad_range();
      bit ok, seen_busy;
      clear_mon();
      sense_mode = 0;
      ready_mode = 1;
      do_start(10, 4);
      seen_busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         if (busy) seen_busy = 1'b1;
      end
      checks++;
      if (err !== 1'b1 || seen_busy || ld_cyc_q.size() !== 0) begin
         errors++;
         $display("FAIL bad_range: err %0b busy seen %0b ld %0d, required 1 0 0", err, seen_busy, ld_cyc_q.size());
      end
      do_start(1, 1);
      @(negedge clk_in);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL err_clear: err %0b busy %0b, required 0 and 1", err, busy);
      end
      wait_idle(600, ok);
      checks++;
      if (!ok || res_tap_q.size() !== 1 || done_n !== 1) begin
         errors++;
         $display("FAIL bad_range_recover: ok %0b results %0d done %0d, required 1 1 1", ok, res_tap_q.size(), done_n);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      clear_mon();
      sense_mode = 0;
      ready_mode = 1;
      do_start(9, 12);
      wait_ld(50, ok);
      repeat (30) tick();
      checks++;
      if (!ok || busy !== 1'b1 || delay !== 5'd9) begin
         errors++;
         $display("FAIL areset_pre: ld seen %0b busy %0b delay %0d, required 1 1 9", ok, busy, delay);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({delay, ld, busy, res_valid, res_tap, res_ones, done, err} !== '0) begin
         errors++;
         $display("FAIL areset_immediate: outputs %h, required 0",
                  {delay, ld, busy, res_valid, res_tap, res_ones, done, err});
      end
      @(negedge clk_in);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_in);
      checks++;
      if (busy !== 1'b0 || delay !== 5'd0 || done_n !== 0) begin
         errors++;
         $display("FAIL areset_after: busy %0b delay %0d done %0d, required 0 0 0", busy, delay, done_n);
      end
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_half_ones();
      test_random_sweep();
      test_backpressure();
      test_rdy_gating();
      test_abort();
      test_bad_range();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
